// File: rtl/tone_synth_pkg.sv
// Shared constants and types for the tone synthesiser.
// Holds the default clock rate, widths, the silence code, the lowest
// audible frequency and the 2-bit encoding of the divide-control FSM.
package tone_synth_pkg;

  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_FREQ_W = 11;
  localparam int DEF_Q_W    = 26;
  localparam int DEF_MIN_HZ = 20;

  // Frequency (and half-period) code meaning "no tone".
  localparam int SILENCE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2
  } tone_state_t;

endpackage

// File: rtl/tone_synth_seq_divider.sv
// Restoring sequential divider: quotient = i_dividend / i_divisor (floor),
// one quotient bit per cycle, MSB first, fixed latency of Q_W cycles.
//
// Handshake: i_start is a single-cycle request; operands are sampled on
// that edge. o_done is high during the cycle in which the final quotient
// bit is computed; o_quotient holds the full result from the following
// cycle until the next i_start. i_abort cancels a divide in progress and
// takes priority over i_start.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_start       begin a divide
//   i_abort       cancel any divide in progress
//   i_dividend    Q_W-bit dividend
//   i_divisor     FREQ_W-bit divisor (never zero when started)
//   o_done        final step in progress
//   o_quotient    Q_W-bit quotient
module tone_synth_seq_divider
  import tone_synth_pkg::*;
#(
  parameter int Q_W    = DEF_Q_W,
  parameter int FREQ_W = DEF_FREQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [Q_W-1:0]    i_dividend,
  input  logic [FREQ_W-1:0] i_divisor,
  output logic              o_done,
  output logic [Q_W-1:0]    o_quotient
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic              r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic [Q_W-1:0]    r_dvd;
  logic [Q_W-1:0]    r_q;
  logic [FREQ_W-1:0] r_dvs;
  logic [FREQ_W-1:0] r_rem;

  logic [FREQ_W:0]   w_trial;
  logic [FREQ_W:0]   w_diff;
  logic              w_ge;

  // Partial remainder is always < divisor, so shifting in one dividend bit
  // needs only one extra bit of headroom.
  always_comb begin
    w_trial = {r_rem, r_dvd[Q_W-1]};
    w_ge    = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial - {1'b0, r_dvs};
  end

  assign o_done     = r_active && (r_cnt == CNT_W'(Q_W - 1));
  assign o_quotient = r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_q      <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_dvd    <= i_dividend;
      r_dvs    <= i_divisor;
      r_rem    <= '0;
      r_q      <= '0;
    end else if (r_active) begin
      r_q   <= {r_q[Q_W-2:0], w_ge};
      r_rem <= w_ge ? w_diff[FREQ_W-1:0] : w_trial[FREQ_W-1:0];
      r_dvd <= {r_dvd[Q_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Square-wave buzzer driver. Converts a requested frequency in Hz into a
// half-period count CLK_HZ/(2*f) with a sequential divider, then toggles
// the buzzer every half-period. New pitches are applied only at half-period
// boundaries so the waveform never carries a truncated pulse.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_en          block enable; low forces silence and aborts a divide
//   i_frequency   requested tone in Hz, 0 = silence
//   o_buzz        square-wave drive
//   o_busy        divider running
//   o_playing     a non-silent half-period is loaded
//   o_state       divide-control FSM state (debug)
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int Q_W    = DEF_Q_W,
  parameter int MIN_HZ = DEF_MIN_HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [FREQ_W-1:0] i_frequency,
  output logic              o_buzz,
  output logic              o_busy,
  output logic              o_playing,
  output tone_state_t       o_state
);

  localparam logic [Q_W-1:0]    DIVIDEND = Q_W'(CLK_HZ / 2);
  localparam logic [FREQ_W-1:0] MIN_F    = FREQ_W'(MIN_HZ);
  localparam logic [Q_W-1:0]    SIL_HALF = Q_W'(SILENCE);

  tone_state_t       r_state, w_state_next;
  logic              w_capture, w_div_start, w_div_done;
  logic [Q_W-1:0]    w_quotient;

  logic [FREQ_W-1:0] r_freq_acc;
  logic              r_silent;     // accepted frequency skips the divide
  logic [Q_W-1:0]    r_half_cur;
  logic [Q_W-1:0]    r_half_pend;
  logic              r_pend_valid;
  logic [Q_W-1:0]    r_cnt;
  logic              r_buzz;
  logic              r_playing;
  logic              w_boundary;

  tone_synth_seq_divider #(.Q_W(Q_W), .FREQ_W(FREQ_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (!i_en),
    .i_dividend (DIVIDEND),
    .i_divisor  (i_frequency),
    .o_done     (w_div_done),
    .o_quotient (w_quotient)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Frequency changes are only looked at in IDLE, so a value that moves
  // during a divide is picked up as a fresh mismatch once the divide ends.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_div_start  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frequency != r_freq_acc) begin
          w_capture = 1'b1;
          if (i_frequency < MIN_F) begin
            w_state_next = ST_LOAD;
          end else begin
            w_state_next = ST_DIV;
            w_div_start  = 1'b1;
          end
        end
      end
      ST_DIV:  if (w_div_done) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (!i_en) begin
      w_state_next = ST_IDLE;
      w_capture    = 1'b0;
      w_div_start  = 1'b0;
    end
  end

  assign w_boundary = (r_half_cur != '0) && (r_cnt == r_half_cur - Q_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_freq_acc   <= '0;
      r_silent     <= 1'b0;
      r_half_cur   <= '0;
      r_half_pend  <= '0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_buzz       <= 1'b0;
      r_playing    <= 1'b0;
    end else if (!i_en) begin
      r_freq_acc   <= '0;
      r_half_cur   <= '0;
      r_pend_valid <= 1'b0;
      r_cnt        <= '0;
      r_buzz       <= 1'b0;
      r_playing    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_freq_acc <= i_frequency;
        r_silent   <= (i_frequency < MIN_F);
      end

      if (r_half_cur != '0) begin
        if (w_boundary) begin
          r_cnt <= '0;
          if (r_pend_valid) begin
            r_half_cur   <= r_half_pend;
            r_pend_valid <= 1'b0;
            if (r_half_pend == SIL_HALF) begin
              r_buzz    <= 1'b0;
              r_playing <= 1'b0;
            end else begin
              r_buzz    <= ~r_buzz;
              r_playing <= 1'b1;
            end
          end else begin
            r_buzz <= ~r_buzz;
          end
        end else begin
          r_cnt <= r_cnt + Q_W'(1);
        end
      end else if (r_pend_valid) begin
        // From silence there is no running half-period to wait for.
        r_half_cur   <= r_half_pend;
        r_cnt        <= '0;
        r_pend_valid <= 1'b0;
        r_playing    <= (r_half_pend != SIL_HALF);
      end

      // Placed last: a result landing on the same edge as a boundary stays
      // pending rather than being cleared by the boundary consuming the old one.
      if (r_state == ST_LOAD) begin
        r_half_pend  <= r_silent ? SIL_HALF : w_quotient;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign o_buzz    = r_buzz;
  assign o_busy    = (r_state == ST_DIV);
  assign o_playing = r_playing;
  assign o_state   = r_state;

endmodule
